// File: rtl/core_reset_sequencer.sv
// core_reset_sequencer
// Owns the core and peripheral reset lines. Merges software, watchdog and
// debug reset requests into one sequence: a minimum assertion window,
// a staggered release (peripherals first, then core) and a cooldown window
// in which new requests are only remembered. Reports the cause of the last
// sequence and a saturating count of requested (non-POR) sequences.
module core_reset_sequencer #(
    parameter int MIN_ASSERT_CYCLES = 16,
    parameter int RELEASE_DELAY     = 4,
    parameter int COOLDOWN_CYCLES   = 8,
    parameter int CNT_W             = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             sw_req,
    input  logic             wdt_req,
    input  logic             dbg_req,
    output logic             core_reset,
    output logic             periph_reset,
    output logic             busy,
    output logic             done,
    output logic [3:0]       reset_cause,
    output logic [CNT_W-1:0] reset_count
);

    // The shared phase counter must reach the largest terminal value.
    localparam int MAXC_AS = (MIN_ASSERT_CYCLES > RELEASE_DELAY) ? MIN_ASSERT_CYCLES : RELEASE_DELAY;
    localparam int MAXC    = (MAXC_AS > COOLDOWN_CYCLES) ? MAXC_AS : COOLDOWN_CYCLES;
    localparam int CW      = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0] ASSERT_LAST  = CW'(MIN_ASSERT_CYCLES - 1);
    localparam logic [CW-1:0] STAGGER_LAST = CW'(RELEASE_DELAY - 1);
    localparam logic [CW-1:0] COOL_LAST    = CW'(COOLDOWN_CYCLES - 1);

    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        STAGGER = 2'd1,
        COOL    = 2'd2,
        RUN     = 2'd3
    } state_t;

    state_t        state_reg;
    logic [CW-1:0] cnt_reg;
    logic [2:0]    pending_reg;   // {dbg, wdt, sw} seen while releasing
    logic [2:0]    req_now;

    assign req_now = {dbg_req, wdt_req, sw_req};

    // Sequencer FSM; every output is a register updated alongside the state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= ASSERT;
            cnt_reg      <= '0;
            pending_reg  <= '0;
            core_reset   <= 1'b1;
            periph_reset <= 1'b1;
            busy         <= 1'b1;
            done         <= 1'b0;
            reset_cause  <= 4'b0001;
            reset_count  <= '0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                ASSERT: begin
                    // Requests during assertion are absorbed into this sequence.
                    reset_cause <= reset_cause | {dbg_req, wdt_req, sw_req, 1'b0};
                    if (cnt_reg == ASSERT_LAST && !dbg_req) begin
                        state_reg    <= STAGGER;
                        cnt_reg      <= '0;
                        periph_reset <= 1'b0;
                    end else if (cnt_reg != ASSERT_LAST) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                STAGGER: begin
                    pending_reg <= pending_reg | req_now;
                    if (cnt_reg == STAGGER_LAST) begin
                        state_reg  <= COOL;
                        cnt_reg    <= '0;
                        core_reset <= 1'b0;
                        done       <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                COOL: begin
                    pending_reg <= pending_reg | req_now;
                    if (cnt_reg == COOL_LAST) begin
                        state_reg <= RUN;
                        cnt_reg   <= '0;
                        busy      <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                RUN: begin
                    // Live and remembered requests start a single new sequence.
                    if (|(req_now | pending_reg)) begin
                        state_reg    <= ASSERT;
                        cnt_reg      <= '0;
                        core_reset   <= 1'b1;
                        periph_reset <= 1'b1;
                        busy         <= 1'b1;
                        reset_cause  <= {req_now | pending_reg, 1'b0};
                        pending_reg  <= '0;
                        if (reset_count != {CNT_W{1'b1}}) begin
                            reset_count <= reset_count + 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg    <= ASSERT;
                    cnt_reg      <= '0;
                    core_reset   <= 1'b1;
                    periph_reset <= 1'b1;
                    busy         <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_reset_sequencer.sv
// Directed bench for core_reset_sequencer with hand-computed expectations.
// Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_core_reset_sequencer;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       sw_req, wdt_req, dbg_req;
    logic       core_reset, periph_reset, busy, done;
    logic [3:0] reset_cause;
    logic [7:0] reset_count;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    core_reset_sequencer #(
        .MIN_ASSERT_CYCLES(16),
        .RELEASE_DELAY    (4),
        .COOLDOWN_CYCLES  (8),
        .CNT_W            (8)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .sw_req      (sw_req),
        .wdt_req     (wdt_req),
        .dbg_req     (dbg_req),
        .core_reset  (core_reset),
        .periph_reset(periph_reset),
        .busy        (busy),
        .done        (done),
        .reset_cause (reset_cause),
        .reset_count (reset_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Bounded wait for the sequencer to return to RUN.
    task automatic wait_run();
        int n = 0;
        while (busy && n < 200) begin
            step(1);
            n++;
        end
        check("wait_run_busy", 32'(busy), 32'd0);
    endtask

    task automatic pulse_sw();
        sw_req = 1'b1;
        step(1);
        sw_req = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        sw_req  = 1'b0;
        wdt_req = 1'b0;
        dbg_req = 1'b0;

        // ---- POR ----
        step(3);
        check("por_core",   32'(core_reset),   32'd1);
        check("por_periph", 32'(periph_reset), 32'd1);
        check("por_busy",   32'(busy),         32'd1);
        check("por_done",   32'(done),         32'd0);
        check("por_cause",  32'(reset_cause),  32'h1);
        check("por_count",  32'(reset_count),  32'd0);
        reset_n = 1'b1;
        step(15);
        check("por_periph_held15", 32'(periph_reset), 32'd1);
        step(1);
        check("por_periph_fall16", 32'(periph_reset), 32'd0);
        check("por_core_held16",   32'(core_reset),   32'd1);
        step(3);
        check("por_core_held19",   32'(core_reset),   32'd1);
        check("por_done_low19",    32'(done),         32'd0);
        step(1);
        check("por_core_fall20",   32'(core_reset),   32'd0);
        check("por_done_pulse",    32'(done),         32'd1);
        step(1);
        check("por_done_one",      32'(done),         32'd0);
        step(6);
        check("por_busy_held27",   32'(busy),         32'd1);
        step(1);
        check("por_busy_fall28",   32'(busy),         32'd0);
        check("por_cause_run",     32'(reset_cause),  32'h1);
        check("por_count_run",     32'(reset_count),  32'd0);
        step(3);
        check("run_idle_core",     32'(core_reset),   32'd0);

        // ---- single SW pulse ----
        pulse_sw();
        check("sw_core_rise", 32'(core_reset),  32'd1);
        check("sw_busy",      32'(busy),        32'd1);
        check("sw_cause",     32'(reset_cause), 32'h2);
        check("sw_count",     32'(reset_count), 32'd1);
        step(19);
        check("sw_core_held20", 32'(core_reset), 32'd1);
        step(1);
        check("sw_core_fall",   32'(core_reset), 32'd0);
        check("sw_done",        32'(done),       32'd1);
        step(7);
        check("sw_busy_held",   32'(busy),       32'd1);
        step(1);
        check("sw_busy_fall",   32'(busy),       32'd0);
        check("sw_cause_hold",  32'(reset_cause), 32'h2);

        // ---- simultaneous SW + WDT ----
        sw_req = 1'b1; wdt_req = 1'b1;
        step(1);
        sw_req = 1'b0; wdt_req = 1'b0;
        check("dual_cause", 32'(reset_cause), 32'h6);
        check("dual_count", 32'(reset_count), 32'd2);
        wait_run();
        check("dual_count_end", 32'(reset_count), 32'd2);

        // ---- debug held 40 cycles ----
        dbg_req = 1'b1;
        step(1);
        check("dbg_core_rise", 32'(core_reset), 32'd1);
        step(39);
        dbg_req = 1'b0;
        check("dbg_periph_held40", 32'(periph_reset), 32'd1);
        step(1);
        check("dbg_periph_fall",   32'(periph_reset), 32'd0);
        check("dbg_cause",         32'(reset_cause),  32'h8);
        check("dbg_count",         32'(reset_count),  32'd3);
        wait_run();

        // ---- WDT during COOL ----
        pulse_sw();
        check("cool_first_count", 32'(reset_count), 32'd4);
        step(20);
        check("cool_done", 32'(done), 32'd1);
        wdt_req = 1'b1;
        step(1);
        wdt_req = 1'b0;
        check("cool_core_low", 32'(core_reset), 32'd0);
        step(6);
        check("cool_busy_held", 32'(busy), 32'd1);
        step(1);
        check("cool_busy_gap", 32'(busy),       32'd0);
        check("cool_gap_core", 32'(core_reset), 32'd0);
        step(1);
        check("cool_second_core",  32'(core_reset),  32'd1);
        check("cool_second_busy",  32'(busy),        32'd1);
        check("cool_second_cause", 32'(reset_cause), 32'h4);
        check("cool_second_count", 32'(reset_count), 32'd5);
        wait_run();

        // ---- reset_n during STAGGER ----
        pulse_sw();
        step(16);
        check("stg_periph_low", 32'(periph_reset), 32'd0);
        check("stg_core_high",  32'(core_reset),   32'd1);
        reset_n = 1'b0;
        #1;
        check("stg_rst_periph", 32'(periph_reset), 32'd1);
        check("stg_rst_core",   32'(core_reset),   32'd1);
        check("stg_rst_count",  32'(reset_count),  32'd0);
        step(2);
        reset_n = 1'b1;
        wait_run();
        check("stg_after_count", 32'(reset_count), 32'd0);
        check("stg_after_cause", 32'(reset_cause), 32'h1);

        // ---- saturation over 256 SW sequences ----
        for (int i = 0; i < 256; i++) begin
            pulse_sw();
            check("sat_count", 32'(reset_count), (i < 255) ? 32'(i + 1) : 32'd255);
            wait_run();
        end
        check("sat_final", 32'(reset_count), 32'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/core_reset_sequencer.md
# core_reset_sequencer

Testbench-side controller that owns the E21 core reset line. It arbitrates reset requests from three sources into one reset sequence: software requests from the DPI-C hook, watchdog expiry and debug ndreset. Each sequence enforces a minimum assertion width, a staggered release (peripherals before core) and a cooldown window. It reports the cause of the last reset and counts the requested resets it has serviced.

## Interface
Parameters:
- MIN_ASSERT_CYCLES, 16, minimum cycles both resets stay asserted (≥1)
- RELEASE_DELAY, 4, cycles between periph_reset release and core_reset release (≥1)
- COOLDOWN_CYCLES, 8, cycles after core release during which new requests are only latched (≥1)
- CNT_W, 8, width of reset_count

Ports:
- clock  input  1  single clock for all state
- reset_n  input  1  asynchronous, active-low reset
- sw_req  input  1  software reset request pulse from the DPI-C hook
- wdt_req  input  1  watchdog reset request pulse
- dbg_req  input  1  debug ndreset, level; holds reset while high
- core_reset  output  1  active-high reset to core, registered
- periph_reset  output  1  active-high reset to peripherals, registered
- busy  output  1  high in any state other than RUN
- done  output  1  one-cycle pulse on the cycle core_reset first reads 0 after a sequence
- reset_cause  output  4  sticky cause of the current/last sequence: [0] POR, [1] SW, [2] WDT, [3] DBG
- reset_count  output  CNT_W  number of non-POR sequences started, saturating

## Operation
- States: ASSERT, STAGGER, COOL, RUN. A single counter `cnt` is cleared on every state entry.
- Asynchronous reset (reset_n=0) sets:
  - state=ASSERT, core_reset=1, periph_reset=1, busy=1, done=0
  - reset_cause=4'b0001, reset_count=0, pending=0, cnt=0
- ASSERT:
  - core_reset=1, periph_reset=1.
  - `cnt` increments each cycle and saturates at MIN_ASSERT_CYCLES-1.
  - sw_req and wdt_req seen here OR into reset_cause; they do not pend.
  - dbg_req high sets cause[3].
  - Exit to STAGGER when cnt==MIN_ASSERT_CYCLES-1 and dbg_req==0.
- STAGGER:
  - periph_reset=0, core_reset=1.
  - After RELEASE_DELAY cycles, go to COOL.
- COOL:
  - Both resets are 0. done=1 on the first COOL cycle only.
  - After COOLDOWN_CYCLES cycles, go to RUN.
- Requests in STAGGER or COOL (sw, wdt, or dbg level) set the matching bit in `pending[2:0]`. They do not abort the release.
- RUN:
  - busy=0.
  - If (sw_req|wdt_req|dbg_req|pending) is nonzero, the next state is ASSERT. On that edge:
    - reset_cause becomes {dbg, wdt, sw} merged from inputs and pending, with bit0=0.
    - pending is cleared.
    - reset_count increments; it saturates at all-ones.
  - Simultaneous requests start one sequence with all of their bits set in the cause. They increment the count once.
- reset_cause holds its value through RUN until the next sequence starts.
- All outputs are registered and decode directly from state. They have no combinational path from the inputs.

## Timing
- Request to assertion: a request sampled high in RUN at edge k gives core_reset=periph_reset=1 from edge k onward. That is 1 cycle of latency.
- ASSERT lasts exactly MIN_ASSERT_CYCLES cycles when dbg_req is low. It is extended cycle-for-cycle while dbg_req is high, and exits on the edge after dbg_req falls, provided the minimum width has elapsed.
- periph_reset deasserts RELEASE_DELAY cycles before core_reset.
- A pulse request arriving during COOL is serviced on the first RUN cycle. So core_reset rises 1 cycle after busy falls, and busy is low for exactly 1 cycle.
- When reset_n is asserted mid-sequence, the block returns to the POR state immediately: pending and reset_count are cleared and reset_cause=0001.
- Total sequence length with defaults: 16 + 4 + 8 = 28 cycles from ASSERT entry to RUN.

## Test plan
- POR: hold reset_n low 3 cycles, then release → periph_reset falls 16 cycles after release, core_reset falls 4 cycles later with done=1 for 1 cycle, busy falls 8 cycles after that; cause=0001, count=0.
- SW pulse in RUN → core_reset=1 on the next edge and stays high for 20 cycles; cause=0010, count=1.
- sw_req and wdt_req in the same RUN cycle → one sequence; cause=0110, count increments by exactly 1.
- dbg_req held high for 40 cycles starting in RUN → ASSERT lasts 40 cycles and exits 1 cycle after dbg_req falls; cause=1000.
- wdt_req pulse during COOL → current release completes with done=1, busy low for 1 cycle, then a second sequence starts with cause=0100.
- reset_n asserted during STAGGER → periph_reset and core_reset both read 1 immediately; after release, count=0 and cause=0001. Also drive 256 SW sequences with CNT_W=8 → count saturates at 255.
